sargantana_icache_repl_policy_unit: RTL and testbench
=====================================================

Name: sargantana_icache_repl_policy_unit

Overview:
Next-generation replacement and valid-bit control unit for the Sargantana instruction cache. It sits between the icache controller and the tag/valid and data RAM banks. It selects the victim way using a compile-time policy: random, tree-PLRU or round-robin. It also performs targeted per-way invalidations and runs a sequential flush/init sweep that clears every set's valid bits and policy state.

Parameters:
ICACHE_N_WAY, 4, number of ways; power of two, at least 2.
ICACHE_IDX_WIDTH, 6, set index width; N_SETS = 2**ICACHE_IDX_WIDTH.
REPL_POLICY, REPL_PLRU, repl_policy_e value: REPL_RANDOM, REPL_PLRU or REPL_RR.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
flush_req_i  in  1  start a flush sweep
flush_busy_o  out  1  sweep in progress; core must stall
flush_done_o  out  1  one-cycle pulse when the sweep ends
inval_valid_i  in  1  invalidation request
inval_idx_i  in  IDX  set to invalidate
inval_way_i  in  clog2(N_WAY)  way to invalidate
inval_ready_o  out  1  invalidation accepted this cycle
cache_rd_ena_i  in  1  core lookup read
cache_wr_ena_i  in  1  refill write
cline_index_i  in  IDX  index of the current read or refill
cmp_en_q_i  in  1  compare stage active
cmp_index_i  in  IDX  index held in the compare stage
hit_i  in  1  compare-stage hit
hit_way_oh_i  in  N_WAY  one-hot hit way
way_valid_bits_i  in  N_WAY  valid bits read for cmp_index_i
way_to_replace_q_i  in  clog2(N_WAY)  registered victim
way_to_replace_d_o  out  clog2(N_WAY)  next victim
we_valid_o  out  1  valid-RAM write enable
valid_wdata_o  out  1  valid bit value to write
addr_valid_o  out  IDX  valid/tag RAM address
tag_req_valid_o  out  N_WAY  tag/valid bank enables
data_req_valid_o  out  N_WAY  data bank enables

Behaviour:
Interface:
- One clock, clk_i.
- Reset rst_i is synchronous, active-high.

FSM (states INIT_FLUSH, IDLE):
- Reset forces INIT_FLUSH with sweep counter = 0. All policy state (PLRU bits, RR pointer) resets to 0; the LFSR resets to its nonzero seed.
- Registered outputs reset to 0: flush_done_o.
- flush_busy_o is 1 in INIT_FLUSH.
- INIT_FLUSH, every cycle:
  - we_valid_o=1, valid_wdata_o=0, tag_req_valid_o='1, data_req_valid_o='0, addr_valid_o=counter.
  - The PLRU state of set[counter] is cleared.
  - The counter increments.
- On the cycle counter==N_SETS-1, the next state is IDLE and flush_done_o=1 in the following cycle for exactly one cycle.
- A sweep therefore takes N_SETS cycles.
- In IDLE, flush_req_i starts a sweep (counter=0) on the next cycle. flush_req_i during a sweep is ignored.
- Reset during a sweep restarts the sweep from 0.

Priority in IDLE: fill > invalidation > read.
- Fill (cache_wr_ena_i):
  - we_valid_o=1, valid_wdata_o=1, addr_valid_o=cline_index_i.
  - tag_req_valid_o and data_req_valid_o = onehot(way_to_replace_q_i).
- inval_ready_o = IDLE & ~cache_wr_ena_i. An invalidation completes in one cycle when inval_valid_i & inval_ready_o:
  - we_valid_o=1, valid_wdata_o=0, addr_valid_o=inval_idx_i.
  - tag_req_valid_o=onehot(inval_way_i), data_req_valid_o='0.
  - The requester holds valid until ready.
- Read:
  - tag_req_valid_o='1, data_req_valid_o='1, addr_valid_o=cline_index_i, we_valid_o=0.
  - A read coinciding with an accepted invalidation gets tag/data enables ORed, but the address is inval_idx_i. The controller must not issue both in the same cycle.
- Otherwise all enables are 0 and addr_valid_o=cline_index_i.

Victim selection:
- way_to_replace_d_o = cmp_en_q_i ? victim : way_to_replace_q_i.
- If any bit of way_valid_bits_i is 0, the victim is the lowest invalid way.
- Otherwise the victim follows the policy:
  - RANDOM: LFSR output; the LFSR advances only on a fill when all ways are valid.
  - PLRU: tree traversal of plru[cmp_index_i], N_WAY-1 bits, heap order, root = bit 0. A bit value of 0 selects the lower half.
  - RR: global pointer; it increments (with wrap-around) on every fill.

PLRU update:
- On cmp_en_q_i & hit_i, plru[cmp_index_i] is updated so every node on the path points away from the hit way.
- On a fill, plru[cline_index_i] is updated the same way for way_to_replace_q_i.
- If both occur on the same set in the same cycle, the fill update wins.
- Sets written by a sweep or an invalidation keep no residual state beyond the sweep clear.

Decomposition:
- sargantana_icache_pkg gains:
  - repl_policy_e enum {REPL_RANDOM, REPL_PLRU, REPL_RR};
  - the flush FSM state enum;
  - the function onehot().
- One sub-module, sargantana_icache_plru_tree: combinational. Inputs: state vector and access way. Outputs: victim way and next state.
- Reuse sargantana_icache_lfsr and sargantana_icache_tzc.

Test Plan:
1. Reset init: N_WAY=4, IDX=6; hold rst_i 2 cycles, then release.
   -> 64 cycles with flush_busy_o=1, we_valid_o=1, valid_wdata_o=0, addr_valid_o 0..63.
   -> flush_done_o high exactly once on the cycle after index 63.
2. Invalid-first victim: way_valid_bits_i=4'b1011, cmp_en_q_i=1.
   -> way_to_replace_d_o=2 for every REPL_POLICY.
3. PLRU: all valid in set 5; hit way 0, then hit way 2.
   -> next victim for set 5 = 1.
   -> set 6 is unaffected: victim 0.
4. Collision: inval_valid_i=1 (idx 9, way 2) with cache_wr_ena_i=1.
   -> Cycle 0: inval_ready_o=0, fill write with valid_wdata_o=1.
   -> Cycle 1: inval accepted, tag_req_valid_o=4'b0100, addr_valid_o=9, valid_wdata_o=0.
5. Flush and reset mid-sweep: flush_req_i in IDLE, then rst_i asserted at sweep index 20.
   -> The sweep restarts at 0.
   -> inval_ready_o=0 and data_req_valid_o=0 throughout, even with cache_rd_ena_i=1.
   -> flush_req_i mid-sweep has no effect.
6. RR/RANDOM: all ways valid, 5 fills.
   -> RR victims are 0,1,2,3,0.
   -> The LFSR output changes only on fill cycles and holds across 10 read-only cycles.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared types and helpers for the icache replacement unit
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        REPL_RANDOM,
        REPL_PLRU,
        REPL_RR
    } repl_policy_e;

    typedef enum logic {
        INIT_FLUSH,
        IDLE
    } flush_state_e;

    localparam int unsigned MAX_WAYS  = 32;
    localparam int unsigned MAX_WAY_W = 5;

    // Callers cast the result down to their own way count.
    function automatic logic [MAX_WAYS-1:0] onehot(input logic [MAX_WAY_W-1:0] idx);
        logic [MAX_WAYS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sargantana_icache_repl_policy_unit_if.sv
// rtl/sargantana_icache_repl_policy_unit_if.sv - tag/valid and data RAM bank request bundle
interface sargantana_icache_repl_policy_unit_if #(
    parameter int unsigned N_WAY     = 4,
    parameter int unsigned IDX_WIDTH = 6
);
    logic                 we_valid;
    logic                 valid_wdata;
    logic [IDX_WIDTH-1:0] addr_valid;
    logic [N_WAY-1:0]     tag_req_valid;
    logic [N_WAY-1:0]     data_req_valid;

    modport master (
        output we_valid, valid_wdata, addr_valid, tag_req_valid, data_req_valid
    );

    modport slave (
        input we_valid, valid_wdata, addr_valid, tag_req_valid, data_req_valid
    );
endinterface

// File: rtl/sargantana_icache_lfsr.sv
// rtl/sargantana_icache_lfsr.sv - 8-bit maximal-length LFSR, advances only when enabled
module sargantana_icache_lfsr #(
    parameter int unsigned OUT_W = 2,
    parameter logic [7:0]  SEED  = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] rnd_o
);
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign rnd_o = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/sargantana_icache_repl_policy_unit_plru_tree.sv
// rtl/sargantana_icache_repl_policy_unit_plru_tree.sv - tree-PLRU victim lookup and access update
module sargantana_icache_plru_tree #(
    parameter int unsigned N_WAY = 4
) (
    input  logic [N_WAY-2:0]         state_i,
    input  logic [$clog2(N_WAY)-1:0] access_way_i,
    output logic [$clog2(N_WAY)-1:0] victim_o,
    output logic [N_WAY-2:0]         state_o
);
    localparam int unsigned WAY_W = $clog2(N_WAY);

    // Heap-ordered nodes: children of node n are 2n+1 (lower half) and 2n+2.
    always_comb begin
        int   vnode;
        int   unode;
        logic b;
        victim_o = '0;
        state_o  = state_i;
        vnode    = 0;
        unode    = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < N_WAY - 1; n++) begin
                if (n == vnode) b = state_i[n];
                if (n == unode) state_o[n] = ~access_way_i[WAY_W-1-l];
            end
            victim_o[WAY_W-1-l] = b;
            vnode = 2 * vnode + (b ? 2 : 1);
            unode = 2 * unode + (access_way_i[WAY_W-1-l] ? 2 : 1);
        end
    end
endmodule

// File: rtl/sargantana_icache_tzc.sv
// rtl/sargantana_icache_tzc.sv - trailing zero count (index of lowest set bit)
module sargantana_icache_tzc #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     empty_o
);
    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = ($clog2(WIDTH))'(i);
        end
    end
endmodule

// File: rtl/sargantana_icache_repl_policy_unit.sv
// rtl/sargantana_icache_repl_policy_unit.sv - icache victim selection, invalidation and flush sweep
module sargantana_icache_repl_policy_unit
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned  ICACHE_N_WAY     = 4,
    parameter int unsigned  ICACHE_IDX_WIDTH = 6,
    parameter repl_policy_e REPL_POLICY      = REPL_PLRU
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_req_i,
    output logic                            flush_busy_o,
    output logic                            flush_done_o,
    input  logic                            inval_valid_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]     inval_idx_i,
    input  logic [$clog2(ICACHE_N_WAY)-1:0] inval_way_i,
    output logic                            inval_ready_o,
    input  logic                            cache_rd_ena_i,
    input  logic                            cache_wr_ena_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]     cline_index_i,
    input  logic                            cmp_en_q_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]     cmp_index_i,
    input  logic                            hit_i,
    input  logic [ICACHE_N_WAY-1:0]         hit_way_oh_i,
    input  logic [ICACHE_N_WAY-1:0]         way_valid_bits_i,
    input  logic [$clog2(ICACHE_N_WAY)-1:0] way_to_replace_q_i,
    output logic [$clog2(ICACHE_N_WAY)-1:0] way_to_replace_d_o,
    sargantana_icache_repl_policy_unit_if.master ram
);
    localparam int unsigned N_SETS = 2 ** ICACHE_IDX_WIDTH;
    localparam int unsigned WAY_W  = $clog2(ICACHE_N_WAY);

    flush_state_e                state_q;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q;
    logic [ICACHE_N_WAY-2:0]     plru_q [N_SETS];
    logic [WAY_W-1:0]            rr_q;

    logic idle, fill, inval_acc, hit_upd;
    logic [WAY_W-1:0] inv_way, hit_way, lfsr_way, plru_victim, policy_victim, victim;
    logic [WAY_W-1:0] fill_victim_unused;
    logic all_valid, hit_oh_empty_unused;
    logic [ICACHE_N_WAY-2:0] hit_next, fill_next;

    assign idle      = (state_q == IDLE);
    assign fill      = idle & cache_wr_ena_i;
    assign inval_acc = idle & ~cache_wr_ena_i & inval_valid_i;
    assign hit_upd   = idle & cmp_en_q_i & hit_i;

    assign flush_busy_o  = (state_q == INIT_FLUSH);
    assign inval_ready_o = idle & ~cache_wr_ena_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= INIT_FLUSH;
            cnt_q        <= '0;
            flush_done_o <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            case (state_q)
                INIT_FLUSH: begin
                    cnt_q <= cnt_q + ICACHE_IDX_WIDTH'(1);
                    if (&cnt_q) begin
                        state_q      <= IDLE;
                        flush_done_o <= 1'b1;
                    end
                end
                default: begin
                    if (flush_req_i) begin
                        state_q <= INIT_FLUSH;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    // The fill update is written last so it overrides a hit on the same set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < N_SETS; s++) plru_q[s] <= '0;
            rr_q <= '0;
        end else if (state_q == INIT_FLUSH) begin
            plru_q[cnt_q] <= '0;
        end else begin
            if (hit_upd) plru_q[cmp_index_i] <= hit_next;
            if (fill) begin
                plru_q[cline_index_i] <= fill_next;
                rr_q                  <= rr_q + WAY_W'(1);
            end
        end
    end

    sargantana_icache_tzc #(.WIDTH(ICACHE_N_WAY)) u_tzc_invalid (
        .in_i(~way_valid_bits_i), .cnt_o(inv_way), .empty_o(all_valid)
    );

    sargantana_icache_tzc #(.WIDTH(ICACHE_N_WAY)) u_tzc_hit (
        .in_i(hit_way_oh_i), .cnt_o(hit_way), .empty_o(hit_oh_empty_unused)
    );

    sargantana_icache_plru_tree #(.N_WAY(ICACHE_N_WAY)) u_plru_cmp (
        .state_i(plru_q[cmp_index_i]), .access_way_i(hit_way),
        .victim_o(plru_victim), .state_o(hit_next)
    );

    sargantana_icache_plru_tree #(.N_WAY(ICACHE_N_WAY)) u_plru_fill (
        .state_i(plru_q[cline_index_i]), .access_way_i(way_to_replace_q_i),
        .victim_o(fill_victim_unused), .state_o(fill_next)
    );

    sargantana_icache_lfsr #(.OUT_W(WAY_W)) u_lfsr (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(fill & all_valid), .rnd_o(lfsr_way)
    );

    always_comb begin
        case (REPL_POLICY)
            REPL_RANDOM: policy_victim = lfsr_way;
            REPL_RR:     policy_victim = rr_q;
            default:     policy_victim = plru_victim;
        endcase
        victim = all_valid ? policy_victim : inv_way;
    end

    assign way_to_replace_d_o = cmp_en_q_i ? victim : way_to_replace_q_i;

    always_comb begin
        ram.we_valid       = 1'b0;
        ram.valid_wdata    = 1'b0;
        ram.addr_valid     = cline_index_i;
        ram.tag_req_valid  = '0;
        ram.data_req_valid = '0;
        if (state_q == INIT_FLUSH) begin
            ram.we_valid      = 1'b1;
            ram.addr_valid    = cnt_q;
            ram.tag_req_valid = '1;
        end else if (cache_wr_ena_i) begin
            ram.we_valid       = 1'b1;
            ram.valid_wdata    = 1'b1;
            ram.tag_req_valid  = ICACHE_N_WAY'(onehot(MAX_WAY_W'(way_to_replace_q_i)));
            ram.data_req_valid = ICACHE_N_WAY'(onehot(MAX_WAY_W'(way_to_replace_q_i)));
        end else begin
            if (inval_acc) begin
                ram.we_valid      = 1'b1;
                ram.addr_valid    = inval_idx_i;
                ram.tag_req_valid = ICACHE_N_WAY'(onehot(MAX_WAY_W'(inval_way_i)));
            end
            if (cache_rd_ena_i) begin
                ram.tag_req_valid  = '1;
                ram.data_req_valid = '1;
            end
        end
    end
endmodule

// File: tb/tb_sargantana_icache_repl_policy_unit.sv
// tb/tb_sargantana_icache_repl_policy_unit.sv - directed bench for the icache replacement unit
module tb_sargantana_icache_repl_policy_unit;
    import sargantana_icache_pkg::*;

    localparam int N_WAY = 4;
    localparam int IDX   = 6;
    localparam int NSETS = 64;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush_req, inval_valid, rd, wr, cmp_en, hit;
    logic [IDX-1:0] inval_idx, cline, cmp_index;
    logic [1:0] inval_way, wq;
    logic [N_WAY-1:0] hit_oh, vbits;

    // Index 0: PLRU, 1: round-robin, 2: random.
    logic       busy [3];
    logic       done [3];
    logic       ready [3];
    logic [1:0] dway [3];

    sargantana_icache_repl_policy_unit_if #(.N_WAY(N_WAY), .IDX_WIDTH(IDX)) ram_plru ();
    sargantana_icache_repl_policy_unit_if #(.N_WAY(N_WAY), .IDX_WIDTH(IDX)) ram_rr ();
    sargantana_icache_repl_policy_unit_if #(.N_WAY(N_WAY), .IDX_WIDTH(IDX)) ram_rnd ();

    sargantana_icache_repl_policy_unit #(.ICACHE_N_WAY(N_WAY), .ICACHE_IDX_WIDTH(IDX), .REPL_POLICY(REPL_PLRU)) dut_plru (
        .clk_i(clk), .rst_i(rst), .flush_req_i(flush_req), .flush_busy_o(busy[0]), .flush_done_o(done[0]),
        .inval_valid_i(inval_valid), .inval_idx_i(inval_idx), .inval_way_i(inval_way), .inval_ready_o(ready[0]),
        .cache_rd_ena_i(rd), .cache_wr_ena_i(wr), .cline_index_i(cline), .cmp_en_q_i(cmp_en),
        .cmp_index_i(cmp_index), .hit_i(hit), .hit_way_oh_i(hit_oh), .way_valid_bits_i(vbits),
        .way_to_replace_q_i(wq), .way_to_replace_d_o(dway[0]), .ram(ram_plru)
    );

    sargantana_icache_repl_policy_unit #(.ICACHE_N_WAY(N_WAY), .ICACHE_IDX_WIDTH(IDX), .REPL_POLICY(REPL_RR)) dut_rr (
        .clk_i(clk), .rst_i(rst), .flush_req_i(flush_req), .flush_busy_o(busy[1]), .flush_done_o(done[1]),
        .inval_valid_i(inval_valid), .inval_idx_i(inval_idx), .inval_way_i(inval_way), .inval_ready_o(ready[1]),
        .cache_rd_ena_i(rd), .cache_wr_ena_i(wr), .cline_index_i(cline), .cmp_en_q_i(cmp_en),
        .cmp_index_i(cmp_index), .hit_i(hit), .hit_way_oh_i(hit_oh), .way_valid_bits_i(vbits),
        .way_to_replace_q_i(wq), .way_to_replace_d_o(dway[1]), .ram(ram_rr)
    );

    sargantana_icache_repl_policy_unit #(.ICACHE_N_WAY(N_WAY), .ICACHE_IDX_WIDTH(IDX), .REPL_POLICY(REPL_RANDOM)) dut_rnd (
        .clk_i(clk), .rst_i(rst), .flush_req_i(flush_req), .flush_busy_o(busy[2]), .flush_done_o(done[2]),
        .inval_valid_i(inval_valid), .inval_idx_i(inval_idx), .inval_way_i(inval_way), .inval_ready_o(ready[2]),
        .cache_rd_ena_i(rd), .cache_wr_ena_i(wr), .cline_index_i(cline), .cmp_en_q_i(cmp_en),
        .cmp_index_i(cmp_index), .hit_i(hit), .hit_way_oh_i(hit_oh), .way_valid_bits_i(vbits),
        .way_to_replace_q_i(wq), .way_to_replace_d_o(dway[2]), .ram(ram_rnd)
    );

    typedef struct {
        logic       wr, rd, iv;
        logic [5:0] iidx;
        logic [1:0] iway;
        logic [5:0] cline;
        logic [1:0] wq;
        logic [3:0] vbits;
        logic       cmp_en;
        logic       e_we, e_wdata;
        logic [5:0] e_addr;
        logic [3:0] e_tag, e_data;
        logic       e_ready;
        logic [1:0] e_dway;
    } vec_t;

    vec_t vecs[8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    initial begin
        logic [7:0] m;
        int exp_idx;

        vecs[0] = '{0,0,0, 0,0, 7,0,4'b1011,1, 0,0, 7,4'h0,4'h0,1,2};
        vecs[1] = '{0,1,0, 0,0, 8,0,4'b1110,1, 0,0, 8,4'hF,4'hF,1,0};
        vecs[2] = '{1,0,0, 0,0,12,3,4'b0111,1, 1,1,12,4'h8,4'h8,0,3};
        vecs[3] = '{0,0,1, 9,1, 4,0,4'b1101,1, 1,0, 9,4'h2,4'h0,1,1};
        vecs[4] = '{0,1,1,33,3, 2,0,4'b0000,1, 1,0,33,4'hF,4'hF,1,0};
        vecs[5] = '{1,1,0, 0,0,63,0,4'b1011,1, 1,1,63,4'h1,4'h1,0,2};
        vecs[6] = '{0,0,0, 0,0, 5,1,4'b0000,0, 0,0, 5,4'h0,4'h0,1,1};
        vecs[7] = '{1,0,1,17,2,40,2,4'b0111,1, 1,1,40,4'h4,4'h4,0,3};

        rst = 1'b1; flush_req = 0; inval_valid = 0; rd = 0; wr = 0; cmp_en = 0; hit = 0;
        inval_idx = 0; cline = 0; cmp_index = 0; inval_way = 0; wq = 0; hit_oh = 0; vbits = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset sweep
        for (int i = 0; i < NSETS; i++) begin
            chk("init_busy", busy[0], 1);
            chk("init_we", ram_plru.we_valid, 1);
            chk("init_wdata", ram_plru.valid_wdata, 0);
            chk("init_addr", ram_plru.addr_valid, i);
            chk("init_tag", ram_plru.tag_req_valid, 4'hF);
            chk("init_done_low", done[0], 0);
            step();
        end
        chk("init_done_pulse", done[0], 1);
        chk("init_busy_end", busy[0], 0);
        chk("init_ready", ready[0], 1);
        step();
        chk("init_done_clear", done[0], 0);

        // Idle decode and invalid-first victims
        for (int v = 0; v < 8; v++) begin
            wr = vecs[v].wr; rd = vecs[v].rd; inval_valid = vecs[v].iv;
            inval_idx = vecs[v].iidx; inval_way = vecs[v].iway; cline = vecs[v].cline;
            wq = vecs[v].wq; vbits = vecs[v].vbits; cmp_en = vecs[v].cmp_en;
            #1;
            chk($sformatf("vec%0d_we", v), ram_plru.we_valid, vecs[v].e_we);
            chk($sformatf("vec%0d_wdata", v), ram_plru.valid_wdata, vecs[v].e_wdata);
            chk($sformatf("vec%0d_addr", v), ram_plru.addr_valid, vecs[v].e_addr);
            chk($sformatf("vec%0d_tag", v), ram_plru.tag_req_valid, vecs[v].e_tag);
            chk($sformatf("vec%0d_data", v), ram_plru.data_req_valid, vecs[v].e_data);
            chk($sformatf("vec%0d_ready", v), ready[0], vecs[v].e_ready);
            for (int d = 0; d < 3; d++)
                chk($sformatf("vec%0d_dway%0d", v, d), dway[d], vecs[v].e_dway);
            step();
        end
        wr = 0; rd = 0; inval_valid = 0;

        // PLRU: hit way 0 then way 2 in set 5
        cmp_en = 1; vbits = 4'hF; cmp_index = 5; hit = 1; hit_oh = 4'b0001;
        step();
        hit_oh = 4'b0100;
        step();
        hit = 0; hit_oh = 0;
        #1;
        chk("plru_set5_victim", dway[0], 1);
        cmp_index = 6;
        #1;
        chk("plru_set6_victim", dway[0], 0);

        // Fill colliding with a pending invalidation
        vbits = 4'b1011; cmp_en = 0;
        inval_valid = 1; inval_idx = 9; inval_way = 2; wr = 1; cline = 3; wq = 1;
        #1;
        chk("coll0_ready", ready[0], 0);
        chk("coll0_wdata", ram_plru.valid_wdata, 1);
        chk("coll0_addr", ram_plru.addr_valid, 3);
        chk("coll0_tag", ram_plru.tag_req_valid, 4'b0010);
        step();
        wr = 0;
        #1;
        chk("coll1_ready", ready[0], 1);
        chk("coll1_tag", ram_plru.tag_req_valid, 4'b0100);
        chk("coll1_addr", ram_plru.addr_valid, 9);
        chk("coll1_wdata", ram_plru.valid_wdata, 0);
        chk("coll1_we", ram_plru.we_valid, 1);
        chk("coll1_data", ram_plru.data_req_valid, 0);
        step();

        // Flush request, mid-sweep request and reset at index 20
        inval_idx = 1; inval_way = 0; rd = 1; flush_req = 1;
        step();
        flush_req = 0;
        exp_idx = 0;
        for (int c = 0; c < 85; c++) begin
            chk("sweep_addr", ram_plru.addr_valid, exp_idx);
            chk("sweep_ready", ready[0], 0);
            chk("sweep_data", ram_plru.data_req_valid, 0);
            chk("sweep_busy", busy[0], 1);
            chk("sweep_done_low", done[0], 0);
            flush_req = (c == 10);
            rst = (c == 20);
            step();
            exp_idx = (c == 20) ? 0 : exp_idx + 1;
        end
        rst = 0; flush_req = 0; rd = 0; inval_valid = 0;
        #1;
        chk("sweep_done_pulse", done[0], 1);
        chk("sweep_busy_end", busy[0], 0);
        step();

        // Round-robin and random victims over five fills, then read-only hold
        m = LFSR_SEED;
        vbits = 4'hF; cmp_en = 1; cline = 20; wq = 0; wr = 1;
        for (int f = 0; f < 5; f++) begin
            #1;
            chk($sformatf("rr_fill%0d", f), dway[1], f % 4);
            chk($sformatf("rnd_fill%0d", f), dway[2], m[1:0]);
            step();
            m = lfsr_next(m);
        end
        wr = 0; rd = 1;
        for (int r = 0; r < 10; r++) begin
            #1;
            chk("rnd_hold", dway[2], m[1:0]);
            chk("rr_hold", dway[1], 1);
            step();
        end
        rd = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
